bin_to_bcd_converter: RTL

Sequential binary-to-BCD converter feeding the four-digit seven-segment driver. It accepts a 14-bit unsigned binary value on a start strobe and converts it with a shift-and-add-3 (double-dabble) engine, one bit per clock. It then presents four registered BCD digits that drive the display's BCD3..BCD0 inputs directly. Values above 9999 saturate to 9999 and raise an overflow flag.

---
 rtl/bin_to_bcd_converter_if.sv | 37 +++
 rtl/bin_to_bcd_converter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_converter_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD converter.
// The master side issues Start/Binary; the slave side returns status and the four digits.
interface bin_to_bcd_converter_if;
  logic        Start;
  logic [13:0] Binary;
  logic        Busy;
  logic        Done;
  logic        Overflow;
  logic [3:0]  BCD3;
  logic [3:0]  BCD2;
  logic [3:0]  BCD1;
  logic [3:0]  BCD0;

  modport master (
    output Start,
    output Binary,
    input  Busy,
    input  Done,
    input  Overflow,
    input  BCD3,
    input  BCD2,
    input  BCD1,
    input  BCD0
  );

  modport slave (
    input  Start,
    input  Binary,
    output Busy,
    output Done,
    output Overflow,
    output BCD3,
    output BCD2,
    output BCD1,
    output BCD0
  );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per clock).
// Inputs above 9999 saturate to 9999 and set Overflow for that result.
module bin_to_bcd_converter (
  input logic                    Clk,
  input logic                    Reset,
  bin_to_bcd_converter_if.slave  bus
);

  localparam logic [13:0] MaxValue  = 14'd9999;
  localparam logic [3:0]  NumShifts = 4'd14;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [13:0] op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] acc_adj;

  // Add 3 to any digit >= 5 so it carries correctly into the next digit after the shift.
  function automatic logic [15:0] add3_digits(input logic [15:0] a);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ? a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
    end
    return r;
  endfunction

  assign acc_adj = add3_digits(acc_q);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          if (bus.Binary > MaxValue) begin
            op_d       = MaxValue;
            ovf_pend_d = 1'b1;
          end else begin
            op_d       = bus.Binary;
            ovf_pend_d = 1'b0;
          end
          acc_d   = 16'd0;
          cnt_d   = NumShifts;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, op_d} = {acc_adj[14:0], op_q, 1'b0};
        cnt_d         = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = acc_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      acc_q      <= 16'd0;
      op_q       <= 14'd0;
      cnt_q      <= 4'd0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= 16'd0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Overflow = ovf_q;
  assign bus.BCD3     = bcd_q[15:12];
  assign bus.BCD2     = bcd_q[11:8];
  assign bus.BCD1     = bcd_q[7:4];
  assign bus.BCD0     = bcd_q[3:0];

  a_digits_valid: assert property (@(posedge Clk) disable iff (!Reset)
    (bcd_q[15:12] <= 4'd9) && (bcd_q[11:8] <= 4'd9) &&
    (bcd_q[7:4] <= 4'd9) && (bcd_q[3:0] <= 4'd9));

  a_done_not_busy: assert property (@(posedge Clk) disable iff (!Reset)
    done_q |-> !busy_q);

endmodule
